// File: rtl/snitch_icache_pkg.sv
// Shared types for the instruction-cache tag controller: configuration record and FSM states.

package snitch_icache_pkg;

   typedef struct packed {
      int unsigned LINE_COUNT;
      int unsigned WAY_COUNT;
      int unsigned TAG_WIDTH;
      int unsigned COUNT_ALIGN;
   } config_t;

   localparam config_t DefaultCfg = '{
      LINE_COUNT:  32,
      WAY_COUNT:   4,
      TAG_WIDTH:   12,
      COUNT_ALIGN: 5
   };

   typedef enum logic [1:0] {
      StInit,
      StIdle,
      StFlush
   } tag_state_e;

   // Stored entry is {valid, error, tag}.
   function automatic int unsigned tag_entry_width(int unsigned tag_width);
      return tag_width + 2;
   endfunction

endpackage

// File: rtl/snitch_icache_tag_serial.sv
// Single-port tag array, one byte-enable bit per way, registered read data.

module snitch_icache_tag_serial #(
   parameter int unsigned Depth  = 32,
   parameter int unsigned Ways   = 4,
   parameter int unsigned EntryW = 14,
   parameter int unsigned AddrW  = 5,
   parameter type sram_cfg_t     = logic
) (
   input  logic                     clk,
   input  sram_cfg_t                sram_cfg,
   input  logic                     req,
   input  logic                     we,
   input  logic [AddrW-1:0]         addr,
   input  logic [Ways*EntryW-1:0]   wdata,
   input  logic [Ways-1:0]          be,
   output logic [Ways*EntryW-1:0]   rdata
);

   logic [Ways*EntryW-1:0] mem [Depth];

   // The behavioural array has no implementation knobs.
   logic unused_cfg;
   assign unused_cfg = ^sram_cfg;

   always_ff @(posedge clk) begin
      if (req) begin
         if (we) begin
            for (int w = 0; w < Ways; w++) begin
               if (be[w]) mem[addr][w*EntryW +: EntryW] <= wdata[w*EntryW +: EntryW];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/snitch_icache_tag_ctrl.sv
// Tag-array controller: init/flush invalidation, 1-cycle lookup with per-way compare, refill writes.

module snitch_icache_tag_ctrl
   import snitch_icache_pkg::*;
#(
   parameter config_t CFG    = DefaultCfg,
   parameter type sram_cfg_t = logic
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  sram_cfg_t                    sram_cfg_i,
   input  logic                         flush_valid_i,
   output logic                         flush_ready_o,
   input  logic                         lookup_valid_i,
   output logic                         lookup_ready_o,
   input  logic [CFG.COUNT_ALIGN-1:0]   lookup_addr_i,
   input  logic [CFG.TAG_WIDTH-1:0]     lookup_tag_i,
   output logic                         rsp_valid_o,
   input  logic                         rsp_ready_i,
   output logic                         rsp_hit_o,
   output logic [CFG.WAY_COUNT-1:0]     rsp_way_o,
   output logic                         rsp_error_o,
   input  logic                         write_valid_i,
   output logic                         write_ready_o,
   input  logic [CFG.COUNT_ALIGN-1:0]   write_addr_i,
   input  logic [CFG.WAY_COUNT-1:0]     write_way_i,
   input  logic [CFG.TAG_WIDTH-1:0]     write_tag_i,
   input  logic                         write_error_i,
   output logic                         busy_o
);

   localparam int unsigned Lines  = CFG.LINE_COUNT;
   localparam int unsigned Ways   = CFG.WAY_COUNT;
   localparam int unsigned TagW   = CFG.TAG_WIDTH;
   localparam int unsigned AddrW  = CFG.COUNT_ALIGN;
   localparam int unsigned EntryW = tag_entry_width(TagW);

   typedef struct packed {
      logic            valid;
      logic            error;
      logic [TagW-1:0] tag;
   } tag_entry_t;

   tag_state_e               state_q, state_d;
   logic [AddrW-1:0]         cnt_q, cnt_d;
   logic                     rsp_valid_q, rsp_valid_d;
   logic [TagW-1:0]          tag_q, tag_d;

   logic                     sram_req, sram_we;
   logic [AddrW-1:0]         sram_addr;
   logic [Ways*EntryW-1:0]   sram_wdata, sram_rdata;
   logic [Ways-1:0]          sram_be;

   tag_entry_t               write_entry;
   tag_entry_t [Ways-1:0]    entries;
   logic [Ways-1:0]          match, err_match;
   logic                     last_idx, stall, multi;

   assign write_entry = '{valid: 1'b1, error: write_error_i, tag: write_tag_i};
   assign last_idx    = (cnt_q == AddrW'(Lines - 1));
   // A stalled response must keep its SRAM rdata, so nothing may touch the array.
   assign stall       = rsp_valid_q && !rsp_ready_i;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      rsp_valid_d    = rsp_valid_q;
      tag_d          = tag_q;
      sram_req       = 1'b0;
      sram_we        = 1'b0;
      sram_addr      = lookup_addr_i;
      sram_wdata     = '0;
      sram_be        = '0;
      lookup_ready_o = 1'b0;
      write_ready_o  = 1'b0;
      flush_ready_o  = 1'b0;
      unique case (state_q)
         StInit, StFlush: begin
            sram_req      = 1'b1;
            sram_we       = 1'b1;
            sram_addr     = cnt_q;
            sram_be       = '1;
            flush_ready_o = (state_q == StFlush) && last_idx;
            if (last_idx) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + AddrW'(1);
            end
         end
         StIdle: begin
            write_ready_o  = !stall;
            lookup_ready_o = !write_valid_i && !stall && !flush_valid_i;
            if (rsp_ready_i) rsp_valid_d = 1'b0;
            if (write_valid_i && !stall) begin
               sram_req   = 1'b1;
               sram_we    = 1'b1;
               sram_addr  = write_addr_i;
               sram_be    = write_way_i;
               sram_wdata = {Ways{write_entry}};
            end else if (lookup_valid_i && lookup_ready_o) begin
               sram_req    = 1'b1;
               rsp_valid_d = 1'b1;
               tag_d       = lookup_tag_i;
            end
            if (flush_valid_i && !rsp_valid_q) state_d = StFlush;
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StInit;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         tag_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         tag_q       <= tag_d;
      end
   end

   snitch_icache_tag_serial #(
      .Depth      (Lines),
      .Ways       (Ways),
      .EntryW     (EntryW),
      .AddrW      (AddrW),
      .sram_cfg_t (sram_cfg_t)
   ) i_tag_serial (
      .clk      (clk_i),
      .sram_cfg (sram_cfg_i),
      .req      (sram_req),
      .we       (sram_we),
      .addr     (sram_addr),
      .wdata    (sram_wdata),
      .be       (sram_be),
      .rdata    (sram_rdata)
   );

   assign entries = sram_rdata;

   always_comb begin
      match     = '0;
      err_match = '0;
      for (int w = 0; w < Ways; w++) begin
         match[w]     = entries[w].valid && (entries[w].tag == tag_q);
         err_match[w] = match[w] && entries[w].error;
      end
   end

   // More than one matching way means the array is corrupted.
   assign multi       = |(match & (match - Ways'(1)));
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_hit_o   = |match;
   assign rsp_way_o   = match;
   assign rsp_error_o = (|err_match) || multi;
   assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_snitch_icache_tag_ctrl.sv
// Scoreboard bench for the tag controller: reference tag array predicts every lookup response.

module tb_snitch_icache_tag_ctrl;

   localparam int Lines = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush_valid = 1'b0, flush_ready;
   logic        lookup_valid = 1'b0, lookup_ready;
   logic [4:0]  lookup_addr = '0;
   logic [11:0] lookup_tag = '0;
   logic        rsp_valid, rsp_ready = 1'b1, rsp_hit, rsp_error;
   logic [3:0]  rsp_way;
   logic        write_valid = 1'b0, write_ready;
   logic [4:0]  write_addr = '0;
   logic [3:0]  write_way = '0;
   logic [11:0] write_tag = '0;
   logic        write_error = 1'b0;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       hit;
      logic [3:0] way;
      logic       err;
   } exp_t;

   exp_t        sb[$];
   logic        mv [Lines][4];
   logic        me [Lines][4];
   logic [11:0] mt [Lines][4];

   snitch_icache_tag_ctrl dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .sram_cfg_i     (1'b0),
      .flush_valid_i  (flush_valid),
      .flush_ready_o  (flush_ready),
      .lookup_valid_i (lookup_valid),
      .lookup_ready_o (lookup_ready),
      .lookup_addr_i  (lookup_addr),
      .lookup_tag_i   (lookup_tag),
      .rsp_valid_o    (rsp_valid),
      .rsp_ready_i    (rsp_ready),
      .rsp_hit_o      (rsp_hit),
      .rsp_way_o      (rsp_way),
      .rsp_error_o    (rsp_error),
      .write_valid_i  (write_valid),
      .write_ready_o  (write_ready),
      .write_addr_i   (write_addr),
      .write_way_i    (write_way),
      .write_tag_i    (write_tag),
      .write_error_i  (write_error),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   function automatic void model_clear();
      for (int s = 0; s < Lines; s++)
         for (int w = 0; w < 4; w++) begin
            mv[s][w] = 1'b0;
            me[s][w] = 1'b0;
            mt[s][w] = '0;
         end
   endfunction

   function automatic exp_t model_lookup(logic [4:0] a, logic [11:0] t);
      exp_t e;
      int n;
      e = '0;
      n = 0;
      for (int w = 0; w < 4; w++) begin
         if (mv[a][w] && mt[a][w] == t) begin
            e.way[w] = 1'b1;
            n++;
            if (me[a][w]) e.err = 1'b1;
         end
      end
      e.hit = (n > 0);
      if (n > 1) e.err = 1'b1;
      return e;
   endfunction

   // Inputs are driven at the falling edge; handshakes are observed just before the rising edge.
   task automatic tick();
      #2;
      if (!rst && write_valid && write_ready)
         for (int w = 0; w < 4; w++)
            if (write_way[w]) begin
               mv[write_addr][w] = 1'b1;
               me[write_addr][w] = write_error;
               mt[write_addr][w] = write_tag;
            end
      if (!rst && lookup_valid && lookup_ready) sb.push_back(model_lookup(lookup_addr, lookup_tag));
      @(negedge clk);
   endtask

   task automatic do_write(logic [4:0] a, logic [3:0] way, logic [11:0] t, logic err);
      write_valid = 1'b1; write_addr = a; write_way = way; write_tag = t; write_error = err;
      tick();
      write_valid = 1'b0;
   endtask

   task automatic do_lookup(logic [4:0] a, logic [11:0] t);
      lookup_valid = 1'b1; lookup_addr = a; lookup_tag = t;
      tick();
      lookup_valid = 1'b0;
   endtask

   always begin
      @(negedge clk);
      #4;
      if (!rst && rsp_valid && rsp_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: got hit=%b way=%b err=%b, required no response",
                     rsp_hit, rsp_way, rsp_error);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({rsp_hit, rsp_way, rsp_error} !== {e.hit, e.way, e.err}) begin
               errors++;
               $display("FAIL rsp_compare: got hit=%b way=%b err=%b, required hit=%b way=%b err=%b",
                        rsp_hit, rsp_way, rsp_error, e.hit, e.way, e.err);
            end
         end
      end
   end

   task automatic test_reset();
      int n;
      rst = 1'b1;
      model_clear();
      sb.delete();
      @(negedge clk);
      #1;
      checks++;
      if ({busy, lookup_ready, write_ready, rsp_valid, flush_ready} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_outputs: got busy/lrdy/wrdy/rvld/frdy=%b, required 10000",
                  {busy, lookup_ready, write_ready, rsp_valid, flush_ready});
      end
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (!busy) break;
         n++;
         tick();
      end
      checks++;
      if (n != Lines) begin
         errors++;
         $display("FAIL init_length: got %0d busy cycles, required %0d", n, Lines);
      end
      for (int s = 0; s < 4; s++) do_lookup(5'(s * 7), 12'($urandom_range(0, 4095)));
      tick();
   endtask

   task automatic test_hit();
      do_write(5'd5, 4'b0010, 12'h1AB, 1'b0);
      lookup_valid = 1'b1; lookup_addr = 5'd5; lookup_tag = 12'h1AB;
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL hit_pre_valid: got rsp_valid=%b, required 0", rsp_valid);
      end
      tick();
      lookup_valid = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL hit_latency: got rsp_valid=%b, required 1", rsp_valid);
      end
      tick();
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rsp_falls: got rsp_valid=%b, required 0", rsp_valid);
      end
      do_lookup(5'd5, 12'h1AC);
      do_lookup(5'd4, 12'h1AB);
      tick();
   endtask

   task automatic test_multi_error();
      do_write(5'd3, 4'b0001, 12'h055, 1'b0);
      do_write(5'd3, 4'b0100, 12'h055, 1'b0);
      do_lookup(5'd3, 12'h055);
      do_write(5'd7, 4'b1000, 12'hFFF, 1'b1);
      do_lookup(5'd7, 12'hFFF);
      do_lookup(5'd7, 12'h000);
      tick();
   endtask

   task automatic test_stall();
      logic [5:0] held;
      rsp_ready = 1'b0;
      do_lookup(5'd5, 12'h1AB);
      lookup_valid = 1'b1; lookup_addr = 5'd5; lookup_tag = 12'h2CD;
      write_valid = 1'b1; write_addr = 5'd5; write_way = 4'b0001;
      write_tag = 12'h2CD; write_error = 1'b0;
      #1;
      held = {rsp_hit, rsp_way, rsp_error};
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if ({rsp_valid, rsp_hit, rsp_way, rsp_error, lookup_ready, write_ready} !== {1'b1, held, 2'b00}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got vld/rsp/lrdy/wrdy=%b/%b/%b%b, required 1/%b/00",
                     i, rsp_valid, {rsp_hit, rsp_way, rsp_error}, lookup_ready, write_ready, held);
         end
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if ({write_ready, lookup_ready} !== 2'b10) begin
         errors++;
         $display("FAIL release_prio: got wrdy/lrdy=%b, required 10", {write_ready, lookup_ready});
      end
      tick();
      write_valid = 1'b0;
      #1;
      checks++;
      if (lookup_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_lookup: got lookup_ready=%b, required 1", lookup_ready);
      end
      tick();
      lookup_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         lookup_valid = 1'b1;
         lookup_addr = 5'(i + 2);
         lookup_tag = (i % 2 == 0) ? 12'h055 : 12'h1AB;
         if (i == 6) lookup_addr = 5'd5;
         #1;
         checks++;
         if (lookup_ready !== 1'b1 || (i > 0 && rsp_valid !== 1'b1)) begin
            errors++;
            $display("FAIL b2b[%0d]: got lookup_ready=%b rsp_valid=%b, required 1/1",
                     i, lookup_ready, rsp_valid);
         end
         tick();
      end
      lookup_valid = 1'b0;
      tick();
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: got rsp_valid=%b, required 0", rsp_valid);
      end
   endtask

   task automatic test_flush();
      int n;
      bit seen;
      flush_valid = 1'b1;
      n = 0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (flush_ready) begin
            seen = 1'b1;
            break;
         end
         n++;
         tick();
      end
      checks++;
      if (!seen || n != Lines) begin
         errors++;
         $display("FAIL flush_length: got %0d cycles (seen=%0b), required %0d", n, seen, Lines);
      end
      tick();
      model_clear();
      flush_valid = 1'b0;
      #1;
      checks++;
      if ({flush_ready, busy} !== 2'b00) begin
         errors++;
         $display("FAIL flush_done: got flush_ready/busy=%b, required 00", {flush_ready, busy});
      end
      do_lookup(5'd5, 12'h1AB);
      do_lookup(5'd3, 12'h055);
      do_lookup(5'd7, 12'hFFF);
      tick();
   endtask

   task automatic test_reset_mid_flush();
      int n;
      do_write(5'd9, 4'b0100, 12'h321, 1'b0);
      flush_valid = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, lookup_ready, write_ready, rsp_valid, flush_ready} !== 5'b10000) begin
         errors++;
         $display("FAIL midflush_reset: got busy/lrdy/wrdy/rvld/frdy=%b, required 10000",
                  {busy, lookup_ready, write_ready, rsp_valid, flush_ready});
      end
      flush_valid = 1'b0;
      model_clear();
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (!busy) break;
         n++;
         tick();
      end
      checks++;
      if (n != Lines) begin
         errors++;
         $display("FAIL reinit_length: got %0d busy cycles, required %0d", n, Lines);
      end
      do_lookup(5'd9, 12'h321);
      tick();
   endtask

   initial begin
      model_clear();
      test_reset();
      test_hit();
      test_multi_error();
      test_stall();
      test_back_to_back();
      test_flush();
      test_reset_mid_flush();
      tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_empty: got %0d outstanding responses, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1);
   end

endmodule
